// File: rtl/sram_pkg.sv
// sram_pkg: clear-FSM state type and byte-lane merge helper shared by sram_2p_bwe.
package sram_pkg;

    typedef enum logic {CLEAR, READY} clr_state_t;

    function automatic logic [7:0] byte_merge(input logic [7:0] old_b, input logic [7:0] new_b, input logic en);
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: LAT-deep (1 or 2) read data/valid delay line; data holds when no read completes.
module sram_rd_pipe #(
    parameter int BW  = 64,
    parameter int LAT = 1
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          in_valid,
    input  logic [BW-1:0] in_data,
    output logic          out_valid,
    output logic [BW-1:0] out_data
);

    logic          s1_valid;
    logic [BW-1:0] s1_data;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) s1_data <= in_data;
        end
    end

    if (LAT == 2) begin : g_lat2
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end else begin
                out_valid <= s1_valid;
                if (s1_valid) out_data <= s1_data;
            end
        end
    end else begin : g_lat1
        assign out_valid = s1_valid;
        assign out_data  = s1_data;
    end

endmodule

// File: rtl/sram_2p_bwe.sv
// sram_2p_bwe: 1R1W SRAM with byte write enables, RD_LAT 1/2 read pipe and power-on clear.
// Define SRAM_FWD_EN to merge a same-edge write into a read of the same address.
module sram_2p_bwe
    import sram_pkg::*;
#(
    parameter int BW     = 64,
    parameter int AW     = 3,
    parameter int ENTRY  = 8,
    parameter int RD_LAT = 1
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            RCSN,
    input  logic [AW-1:0]   RA,
    output logic [BW-1:0]   DOUT,
    output logic            RVALID,
    input  logic            WCSN,
    input  logic [AW-1:0]   WA,
    input  logic [BW/8-1:0] WBE,
    input  logic [BW-1:0]   DI,
    output logic            BUSY
);

    localparam int NB = BW / 8;

    clr_state_t    state;
    logic [AW-1:0] cnt;
    logic [BW-1:0] ram [ENTRY];
    logic [BW-1:0] rd_old, wr_old, wr_word, rd_data;
    logic          rd_ok, wr_ok;

    assign rd_ok  = (state == READY) && !RCSN;
    assign wr_ok  = (state == READY) && !WCSN && (32'(WA) < ENTRY);
    assign rd_old = (32'(RA) < ENTRY) ? ram[RA] : '0;
    assign wr_old = ram[WA];

    for (genvar i = 0; i < NB; i++) begin : g_wr_lane
        assign wr_word[8*i +: 8] = byte_merge(wr_old[8*i +: 8], DI[8*i +: 8], WBE[i]);
    end

`ifdef SRAM_FWD_EN
    logic [BW-1:0] fwd_word;
    for (genvar i = 0; i < NB; i++) begin : g_fwd_lane
        assign fwd_word[8*i +: 8] = byte_merge(rd_old[8*i +: 8], DI[8*i +: 8], WBE[i]);
    end
    assign rd_data = (wr_ok && WA == RA) ? fwd_word : rd_old;
`else
    assign rd_data = rd_old;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= CLEAR;
            cnt   <= '0;
            BUSY  <= 1'b1;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == AW'(ENTRY - 1)) begin
                state <= READY;
                BUSY  <= 1'b0;
            end
        end
    end

    // The array has no reset; the clear sequence zeroes it one word per edge.
    always_ff @(posedge CLK) begin
        if (state == CLEAR) ram[cnt] <= '0;
        else if (wr_ok) ram[WA] <= wr_word;
    end

    sram_rd_pipe #(.BW(BW), .LAT(RD_LAT)) u_rd_pipe (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .in_valid (rd_ok),
        .in_data  (rd_data),
        .out_valid(RVALID),
        .out_data (DOUT)
    );

endmodule
